instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 188 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit feeding decode through a first-word-fall-through prefetch FIFO.
// Defining INSTR_FETCH_PERF_CNT_EN adds the fetch_cnt decode-handshake counter output.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    output logic [15:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_RSP = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              req_hold_r;
    logic [15:0]       instr_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              req_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_LAST) ? {PTR_W{1'b0}} : p + 1'b1;
    endfunction

    // Request/handshake qualifiers; a stalled request is held even if halt rises
    always_comb begin
        req_s = 1'b0;
        if ((state_r == RUN) && reset) begin
            req_s = req_hold_r || (!halt && (count_r < CNT_FULL));
        end else begin
            req_s = 1'b0;
        end
        accept_s = req_s && imem_ready;
        push_s   = (state_r == WAIT_RSP) && imem_rvalid && !redirect_valid;
        pop_s    = (count_r != {CNT_W{1'b0}}) && id_ready;
    end

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign if_valid  = (count_r != {CNT_W{1'b0}});

    // FIFO head presented to decode, zeroed when empty
    always_comb begin
        if_instr = 16'h0000;
        if_pc    = {ADDR_W{1'b0}};
        if (count_r != {CNT_W{1'b0}}) begin
            if_instr = instr_mem_r[rd_ptr_r];
            if_pc    = pc_mem_r[rd_ptr_r];
        end else begin
            if_instr = 16'h0000;
            if_pc    = {ADDR_W{1'b0}};
        end
    end

    // Next-state logic; a redirect that meets the response in WAIT_RSP has nothing left to discard
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (redirect_valid) begin
                    state_nxt_s = accept_s ? DISCARD : RUN;
                end else if (accept_s) begin
                    state_nxt_s = WAIT_RSP;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    state_nxt_s = RUN;
                end else if (redirect_valid) begin
                    state_nxt_s = DISCARD;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // State, fetch address and outstanding-request bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= RUN;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= RESET_PC;
            req_hold_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            req_hold_r <= req_s && !imem_ready && !redirect_valid;
            if (accept_s) begin
                req_addr_r <= fetch_pc_r;
            end
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc;
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 1'b1;
            end
        end
    end

    // Prefetch FIFO; a redirect empties it after any same-cycle pop has completed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 16'h0000;
                pc_mem_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (redirect_valid) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]    <= req_addr_r;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_r;

    // Decode handshake counter, survives redirects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_r <= 16'h0000;
        end else if (pop_s) begin
            fetch_cnt_r <= fetch_cnt_r + 16'h0001;
        end
    end

    assign fetch_cnt = fetch_cnt_r;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a program-order scoreboard.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int DEPTH_TB = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .DEPTH(DEPTH_TB)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: one pending response, delivered after a random delay, data = addr + 0x1000
    bit          out_valid;
    int          out_delay;
    logic [15:0] out_addr;
    int          rdy_pct;
    int          dmin;
    int          dmax;
    bit          inject_stale;
    // Program-order scoreboard
    logic [15:0] exp_fetch;
    logic [15:0] exp_pc;
    logic [15:0] hs16;
    bit          prev_hold;
    logic [15:0] prev_addr;
    // Last cycle's samples
    logic        s_req;
    logic [15:0] s_addr;
    logic        s_ifv;
    logic [15:0] s_pc;
    logic [15:0] s_instr;
    bit          last_hs;
    logic [15:0] last_pc;
    logic [15:0] last_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          rv;
        bit          acc;
        bit          hs;
        logic [15:0] exp_instr;
        imem_ready = ($urandom_range(99) < rdy_pct);
        rv = out_valid && (out_delay == 0);
        if (rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = out_addr + 16'h1000;
        end else if (inject_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hDEAD;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_ifv   = if_valid;
        s_pc    = if_pc;
        s_instr = if_instr;
        acc = (imem_req === 1'b1) && imem_ready;
        hs  = (if_valid === 1'b1) && id_ready;
        if (out_valid) chk("one_outstanding", imem_req, 0);
        if (prev_hold) begin
            chk("req_stable", imem_req, 1);
            chk("addr_stable", imem_addr, prev_addr);
        end else if (halt) begin
            chk("halt_no_req", imem_req, 0);
        end
        if (acc) chk("req_addr", imem_addr, exp_fetch);
        if (hs) begin
            exp_instr = exp_pc + 16'h1000;
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, exp_instr);
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, hs16);
`endif
        prev_hold = (imem_req === 1'b1) && !imem_ready && !redirect_valid;
        prev_addr = imem_addr;
        @(posedge clk);
        if (rv) out_valid = 1'b0;
        else if (out_valid) out_delay--;
        if (acc) begin
            out_valid = 1'b1;
            out_addr  = s_addr;
            out_delay = $urandom_range(dmax, dmin);
            exp_fetch = s_addr + 16'd1;
        end
        last_hs = hs;
        if (hs) begin
            exp_pc     = exp_pc + 16'd1;
            hs16       = hs16 + 16'd1;
            last_pc    = s_pc;
            last_instr = s_instr;
        end
        if (redirect_valid) begin
            exp_fetch = redirect_pc;
            exp_pc    = redirect_pc;
        end
        inject_stale = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("rst_if_valid", if_valid, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 0);
`endif
        @(negedge clk);
        reset     = 1'b1;
        out_valid = 1'b0;
        exp_fetch = 16'h0000;
        exp_pc    = 16'h0000;
        hs16      = 16'h0000;
        prev_hold = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = last_hs;
        end
        chk(tag, got, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n;
        reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
        redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; id_ready = 1'b0;
        out_valid = 1'b0; out_delay = 0; out_addr = 16'h0000; inject_stale = 1'b0;
        rdy_pct = 100; dmin = 0; dmax = 0; prev_hold = 1'b0; prev_addr = 16'h0000;
        exp_fetch = 16'h0000; exp_pc = 16'h0000; hs16 = 16'h0000; last_hs = 1'b0;
        last_pc = 16'h0000; last_instr = 16'h0000;

        // Reset, request in first cycle, stale response ignored, 2-cycle latency, in-order stream
        do_reset();
        id_ready = 1'b1;
        inject_stale = 1'b1;
        tick();
        chk("req_after_reset", s_req, 1);
        tick();
        chk("lat_n1_ifv", s_ifv, 0);
        tick();
        chk("lat_n2_ifv", s_ifv, 1);
        for (int i = 0; i < 20 && hs16 != 16'd4; i++) tick();
        chk("four_fetched", hs16, 4);

        // Decode stalled: FIFO fills to DEPTH, requests stop, drain gives exactly DEPTH
        id_ready = 1'b0;
        repeat (10) tick();
        chk("full_no_req", s_req, 0);
        halt = 1'b1;
        id_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!last_hs) break;
            n++;
        end
        chk("drain_count", n, DEPTH_TB);
        chk("drained_ifv", s_ifv, 0);
        halt = 1'b0;
        tick();
        chk("resume_req", s_req, 1);

        // Redirect while a response is outstanding
        dmin = 1; dmax = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_delay > 0) found = 1'b1;
            else tick();
        end
        chk("wait_rsp_found", found, 1);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        wait_hs("hs_after_redir", 20);
        chk("redir_pc", last_pc, 16'h0040);
        chk("redir_instr", last_instr, 16'h1040);

        // Redirect coinciding with a handshake and a response
        dmin = 2; dmax = 3;
        id_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if ((if_valid === 1'b1) && out_valid && out_delay == 0) found = 1'b1;
            else tick();
        end
        chk("coincide_found", found, 1);
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick();
        chk("hs_in_redir", last_hs, 1);
        redirect_valid = 1'b0;
        tick();
        chk("flush_ifv", s_ifv, 0);
        wait_hs("hs_after_flush", 20);
        chk("flush_pc", last_pc, 16'h0100);

        // Address wrap, then halt mid-stream
        dmin = 0; dmax = 1;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect_valid = 1'b0;
        wait_hs("hs_wrap0", 20);
        chk("wrap_pc0", last_pc, 16'hFFFF);
        chk("wrap_instr0", last_instr, 16'h0FFF);
        wait_hs("hs_wrap1", 20);
        chk("wrap_pc1", last_pc, 16'h0000);
        rdy_pct = 60;
        halt = 1'b1;
        repeat (15) tick();
        chk("halt_drained", s_ifv, 0);
        halt = 1'b0;
        wait_hs("hs_after_halt", 30);

        // Randomized traffic
        dmin = 0; dmax = 3;
        for (int i = 0; i < 2000; i++) begin
            rdy_pct = $urandom_range(90, 20);
            id_ready = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc = ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom);
            if ($urandom_range(99) < 5) halt = ~halt;
            tick();
        end
        redirect_valid = 1'b0; halt = 1'b0; id_ready = 1'b1; rdy_pct = 100;
        wait_hs("hs_after_random", 40);

        // Reset in the middle of fetching
        dmin = 0; dmax = 1;
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 40 && hs16 != 16'd5; i++) tick();
        chk("five_hs", hs16, 5);
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("cnt_before_rst", fetch_cnt, 16'd5);
`endif
        do_reset();
        id_ready = 1'b1;
        inject_stale = 1'b1;
        wait_hs("hs_after_rst2", 20);
        chk("rst2_pc", last_pc, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
